ram_burst_reader: RTL and testbench
===================================

RAM_BURST_READER -- requirements
Module: ram_burst_reader

Interface
REQ-001 Parameter ADDR_SIZE, default 6: dual-port RAM address width; depth is 2**ADDR_SIZE words.
REQ-002 Parameter DATA_SIZE, default 32: word width.
REQ-003 Parameter BURST_LEN, default 8: words per burst; power of two, 2 <= BURST_LEN <= 2**ADDR_SIZE.
REQ-004 Interface is one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  sole clock; all state on rising edge.
REQ-006 nreset  in  1  asynchronous active-low reset.
REQ-007 wr_ptr  in  ADDR_SIZE+1  writer's next-write pointer, with wrap bit, same clock domain.
REQ-008 rd_ptr  out  ADDR_SIZE+1  reader pointer with wrap bit, returned to the writer for full detection.
REQ-009 ram_addr_B  out  ADDR_SIZE  drives the RAM read-only port address.
REQ-010 ram_data_B  in  DATA_SIZE  RAM port-B registered data, valid one cycle after address.
REQ-011 burst_req  out  1  a full burst is available.
REQ-012 burst_ack  in  1  downstream accepts the burst request.
REQ-013 out_valid / out_ready  out / in  1 / 1  stream handshake; transfer when both are high.
REQ-014 out_data  out  DATA_SIZE  stream word.
REQ-015 out_last  out  1  marks the BURST_LEN-th word of a burst.

Function
REQ-016 level SHALL be (wr_ptr - rd_ptr) mod 2**(ADDR_SIZE+1); valid range 0..2**ADDR_SIZE.
REQ-017 FSM states SHALL be IDLE, REQ and STREAM.
REQ-018 IDLE -> REQ SHALL occur when level >= BURST_LEN.
REQ-019 In REQ, burst_req SHALL be 1 and SHALL stay high until burst_ack; burst_ack in any other state SHALL be ignored.
REQ-020 REQ -> STREAM SHALL occur on burst_ack; the issue counter and the output counter SHALL load BURST_LEN.
REQ-021 Read issue: ram_addr_B = rd_ptr[ADDR_SIZE-1:0]; a read SHALL be issued only in STREAM with the issue counter > 0 and (skid_count + inflight - pop) < 2.
REQ-022 Each issue SHALL increment rd_ptr by 1 (wrapping at 2**(ADDR_SIZE+1)) and decrement the issue counter.
REQ-023 The data of a read issued in cycle N SHALL enter the 2-entry skid FIFO in cycle N+1; out_data/out_valid SHALL reflect the FIFO head.
REQ-024 With out_ready held high, throughput SHALL be 1 word/cycle; first out_valid SHALL occur 2 cycles after burst_ack is sampled.
REQ-025 On out_ready low, reads SHALL stall with no word lost or duplicated; out_data SHALL stay stable while out_valid && !out_ready.
REQ-026 out_last SHALL be 1 exactly when the output counter is 1 and out_valid is 1.
REQ-027 STREAM -> IDLE SHALL occur on the out_last transfer; a new REQ may be raised the following cycle.
REQ-028 rd_ptr wrap from 2**(ADDR_SIZE+1)-1 to 0 SHALL be seamless inside a burst.
REQ-029 Words SHALL be emitted in strict address order.
REQ-030 When level = 2**ADDR_SIZE (RAM full), reading SHALL proceed normally.
REQ-031 A writer overwrite of the address being read in the same cycle is safe (the RAM returns old data) and SHALL need no handling.

Reset
REQ-032 nreset low SHALL asynchronously force: state IDLE, rd_ptr 0, ram_addr_B 0, counters 0, skid FIFO empty, burst_req 0, out_valid 0, out_last 0, out_data 0.
REQ-033 Reset mid-burst SHALL abandon the burst with no further out_valid; the writer shares nreset and restarts at 0.

Structure
REQ-034 The package video_in_pkg SHALL hold ADDR_SIZE, DATA_SIZE, BURST_LEN defaults and the state enum typedef.
REQ-035 The 2-entry skid FIFO SHALL be the sub-module skid_fifo2; everything else is inline.

Verification
REQ-036 Reset, then wr_ptr=8, ack one cycle after req, ready=1 -> burst_req the cycle after wr_ptr=8; 8 words, addresses 0..7, contiguous; out_last on word 8; rd_ptr=8.
REQ-037 wr_ptr=7 -> burst_req never asserts; then wr_ptr=8 -> burst_req next cycle.
REQ-038 Burst from rd_ptr=60, wr_ptr=68 (wrap) -> addresses 60..63,0..3 in order; rd_ptr=68.
REQ-039 out_ready toggled 1/0 every cycle, then held low 5 cycles mid-burst -> 8 distinct words in order, data stable while stalled, no extra reads.
REQ-040 wr_ptr=64 (full), rd_ptr=0 -> 8 back-to-back bursts, 64 words, rd_ptr=64, final level 0.
REQ-041 nreset asserted after word 3 of a burst -> all outputs 0 immediately; after release, no out_valid until level >= 8 again.

Source files
------------

// File: rtl/video_in_pkg.sv
// rtl/video_in_pkg.sv - shared defaults and FSM state encoding for the RAM burst reader
package video_in_pkg;

    localparam int ADDR_SIZE_DEF = 6;
    localparam int DATA_SIZE_DEF = 32;
    localparam int BURST_LEN_DEF = 8;

    // Raw encodings kept as plain constants so legacy code can still compare against them.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REQ    = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        REQ    = ST_REQ,
        STREAM = ST_STREAM
    } state_t;

endpackage

// File: rtl/ram_burst_reader_if.sv
// rtl/ram_burst_reader_if.sv - burst request and output stream handshake bundle
//
// burst_req  : reader -> consumer, a full burst is ready
// burst_ack  : consumer -> reader, burst accepted
// out_valid  : reader -> consumer, out_data holds a word
// out_ready  : consumer -> reader, word taken when both valid and ready are high
// out_data   : stream word
// out_last   : marks the final word of a burst
interface ram_burst_reader_if
    import video_in_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DEF
) ();

    logic                 burst_req;
    logic                 burst_ack;
    logic                 out_valid;
    logic                 out_ready;
    logic [DATA_SIZE-1:0] out_data;
    logic                 out_last;

    modport master (
        output burst_req,
        input  burst_ack,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_last
    );

    modport slave (
        input  burst_req,
        output burst_ack,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_last
    );

endinterface

// File: rtl/skid_fifo2.sv
// rtl/skid_fifo2.sv - two-entry FIFO absorbing RAM read latency in front of the output stream
//
// clk, nreset : clock, asynchronous active-low reset
// push        : write push_data this cycle (caller guarantees not full)
// push_data   : word to store
// pop         : drop the head this cycle (caller guarantees not empty)
// head_data   : oldest stored word
// head_valid  : at least one word stored
// count       : number of stored words, 0..2
module skid_fifo2
    import video_in_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DEF
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic                 push,
    input  logic [DATA_SIZE-1:0] push_data,
    input  logic                 pop,
    output logic [DATA_SIZE-1:0] head_data,
    output logic                 head_valid,
    output logic [1:0]           count
);

    logic [DATA_SIZE-1:0] mem [2];
    logic                 wr_idx;
    logic                 rd_idx;
    logic [1:0]           cnt;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_idx <= 1'b0;
            rd_idx <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_idx] <= push_data;
                wr_idx      <= ~wr_idx;
            end
            if (pop) begin
                rd_idx <= ~rd_idx;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign head_data  = mem[rd_idx];
    assign head_valid = (cnt != 2'd0);
    assign count      = cnt;

endmodule

// File: rtl/ram_burst_reader.sv
// rtl/ram_burst_reader.sv - reads fixed-length bursts out of a dual-port RAM ring onto a stream
//
// clk, nreset : clock, asynchronous active-low reset
// wr_ptr      : writer's next-write pointer with wrap bit
// rd_ptr      : reader pointer with wrap bit, fed back to the writer
// ram_addr_B  : RAM read-port address
// ram_data_B  : RAM read-port data, registered, valid the cycle after the address
// strm        : burst request/ack and output stream (master side)
module ram_burst_reader
    import video_in_pkg::*;
#(
    parameter int ADDR_SIZE = ADDR_SIZE_DEF,
    parameter int DATA_SIZE = DATA_SIZE_DEF,
    parameter int BURST_LEN = BURST_LEN_DEF
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic [ADDR_SIZE:0]   wr_ptr,
    output logic [ADDR_SIZE:0]   rd_ptr,
    output logic [ADDR_SIZE-1:0] ram_addr_B,
    input  logic [DATA_SIZE-1:0] ram_data_B,
    ram_burst_reader_if.master   strm
);

    localparam logic [ADDR_SIZE:0] BURST_LEN_W = (ADDR_SIZE+1)'(BURST_LEN);
    localparam logic [ADDR_SIZE:0] ONE_W       = (ADDR_SIZE+1)'(1);

    state_t               state;
    logic [ADDR_SIZE:0]   level;
    logic [ADDR_SIZE:0]   issue_cnt;
    logic [ADDR_SIZE:0]   out_cnt;
    logic                 inflight;
    logic                 issue;
    logic                 pop;
    logic [1:0]           skid_count;
    logic [2:0]           occ_next;
    logic                 head_valid;
    logic [DATA_SIZE-1:0] head_data;

    // Modular difference; the wrap bit makes a full RAM read as 2**ADDR_SIZE rather than 0.
    assign level = wr_ptr - rd_ptr;

    assign pop = head_valid && strm.out_ready;

    // FIFO occupancy once this cycle's returning read and pop settle; a new read is
    // only issued if its data is guaranteed a free slot next cycle.
    assign occ_next = {1'b0, skid_count} + {2'b00, inflight} - {2'b00, pop};
    assign issue    = (state == STREAM) && (issue_cnt != '0) && (occ_next < 3'd2);

    assign ram_addr_B = rd_ptr[ADDR_SIZE-1:0];

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state     <= IDLE;
            rd_ptr    <= '0;
            issue_cnt <= '0;
            out_cnt   <= '0;
            inflight  <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                rd_ptr    <= rd_ptr + ONE_W;
                issue_cnt <= issue_cnt - ONE_W;
            end
            if (pop) begin
                out_cnt <= out_cnt - ONE_W;
            end
            case (state)
                IDLE: begin
                    if (level >= BURST_LEN_W) begin
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (strm.burst_ack) begin
                        state     <= STREAM;
                        issue_cnt <= BURST_LEN_W;
                        out_cnt   <= BURST_LEN_W;
                    end
                end
                STREAM: begin
                    if (pop && strm.out_last) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    skid_fifo2 #(
        .DATA_SIZE (DATA_SIZE)
    ) u_skid (
        .clk        (clk),
        .nreset     (nreset),
        .push       (inflight),
        .push_data  (ram_data_B),
        .pop        (pop),
        .head_data  (head_data),
        .head_valid (head_valid),
        .count      (skid_count)
    );

    assign strm.burst_req = (state == REQ);
    assign strm.out_valid = head_valid;
    assign strm.out_data  = head_data;
    assign strm.out_last  = head_valid && (out_cnt == ONE_W);

endmodule

// File: tb/tb_ram_burst_reader.sv
// tb/tb_ram_burst_reader.sv - directed self-checking bench for ram_burst_reader
module tb_ram_burst_reader;

    localparam int AW = 6;
    localparam int DW = 32;

    logic          clk;
    logic          nreset;
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW-1:0] ram_addr_B;
    logic [DW-1:0] ram_data_B;
    logic [DW-1:0] ram [64];

    int errors = 0;
    int checks = 0;

    ram_burst_reader_if #(.DATA_SIZE(DW)) strm_if ();

    ram_burst_reader dut (
        .clk        (clk),
        .nreset     (nreset),
        .wr_ptr     (wr_ptr),
        .rd_ptr     (rd_ptr),
        .ram_addr_B (ram_addr_B),
        .ram_data_B (ram_data_B),
        .strm       (strm_if)
    );

    always #5 clk = ~clk;

    // Registered read port of the dual-port RAM.
    always @(posedge clk) ram_data_B <= ram[ram_addr_B];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_ram(input logic [31:0] base);
        for (int i = 0; i < 64; i++) ram[i] = base + 32'(i);
    endtask

    // Waits for burst_req, holds one cycle, then pulses burst_ack for one cycle.
    task automatic req_ack(input string tag);
        int n = 0;
        while (!strm_if.burst_req && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_req_seen"}, strm_if.burst_req, 1'b1);
        tick();
        chk({tag, "_req_held"}, strm_if.burst_req, 1'b1);
        strm_if.burst_ack = 1'b1;
        tick();
        strm_if.burst_ack = 1'b0;
    endtask

    // mode 0: ready always high; mode 1: ready toggles, plus a 5-cycle stall after word 4.
    task automatic recv_burst(input int start_addr, input logic [31:0] dbase, input int mode,
                              input int stop_after, input string tag);
        int got = 0;
        int cyc = 0;
        int hold = 0;
        int first_cyc = -1;
        int last_cyc = -1;
        logic rdy;
        logic prev_stall = 1'b0;
        logic [31:0] prev_data = '0;
        logic [31:0] exp;
        while (got < stop_after && cyc < 200) begin
            if (prev_stall) begin
                chk({tag, "_stall_valid"}, strm_if.out_valid, 1'b1);
                chk({tag, "_stall_data"}, strm_if.out_data, prev_data);
            end
            if (mode == 0) begin
                rdy = 1'b1;
            end else if (hold > 0) begin
                rdy = 1'b0;
                hold--;
            end else begin
                rdy = (cyc % 2 == 0);
            end
            strm_if.out_ready = rdy;
            if (strm_if.out_valid && rdy) begin
                exp = dbase + 32'((start_addr + got) % 64);
                chk({tag, "_data"}, strm_if.out_data, exp);
                chk({tag, "_last"}, strm_if.out_last, (got == 7));
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                got++;
                if (mode == 1 && got == 4) hold = 5;
            end
            prev_stall = strm_if.out_valid && !rdy;
            prev_data  = strm_if.out_data;
            cyc++;
            tick();
        end
        strm_if.out_ready = 1'b1;
        chk({tag, "_word_count"}, 64'(got), 64'(stop_after));
        if (mode == 0 && stop_after == 8)
            chk({tag, "_contiguous"}, 64'(last_cyc - first_cyc), 64'd7);
        if (stop_after == 8)
            chk({tag, "_idle_after"}, strm_if.out_valid, 1'b0);
    endtask

    initial begin
        int seen;
        clk = 1'b0;
        nreset = 1'b0;
        wr_ptr = '0;
        strm_if.burst_ack = 1'b0;
        strm_if.out_ready = 1'b1;
        fill_ram(32'hA500_0000);
        #2;
        chk("rst_rd_ptr", rd_ptr, 7'd0);
        chk("rst_ram_addr", ram_addr_B, 6'd0);
        chk("rst_burst_req", strm_if.burst_req, 1'b0);
        chk("rst_out_valid", strm_if.out_valid, 1'b0);
        chk("rst_out_last", strm_if.out_last, 1'b0);
        chk("rst_out_data", strm_if.out_data, 32'd0);
        tick();
        tick();
        nreset = 1'b1;
        tick();

        // First burst: latency and contiguous streaming.
        wr_ptr = 7'd8;
        chk("b0_req_before", strm_if.burst_req, 1'b0);
        tick();
        chk("b0_req_next_cycle", strm_if.burst_req, 1'b1);
        tick();
        chk("b0_req_held", strm_if.burst_req, 1'b1);
        strm_if.burst_ack = 1'b1;
        tick();
        strm_if.burst_ack = 1'b0;
        chk("b0_valid_lat0", strm_if.out_valid, 1'b0);
        tick();
        chk("b0_valid_lat1", strm_if.out_valid, 1'b0);
        tick();
        chk("b0_valid_lat2", strm_if.out_valid, 1'b1);
        recv_burst(0, 32'hA500_0000, 0, 8, "b0");
        chk("b0_rd_ptr", rd_ptr, 7'd8);

        // Level 7: no request, and a stray ack while idle does nothing.
        wr_ptr = 7'd15;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) strm_if.burst_ack = 1'b1;
            if (i == 4) strm_if.burst_ack = 1'b0;
            tick();
            if (strm_if.burst_req || strm_if.out_valid) seen++;
        end
        chk("lvl7_no_req", 64'(seen), 64'd0);
        chk("lvl7_rd_ptr", rd_ptr, 7'd8);
        wr_ptr = 7'd16;
        chk("lvl8_req_before", strm_if.burst_req, 1'b0);
        tick();
        chk("lvl8_req_next", strm_if.burst_req, 1'b1);
        strm_if.burst_ack = 1'b1;
        tick();
        strm_if.burst_ack = 1'b0;
        recv_burst(8, 32'hA500_0000, 1, 8, "stall");
        chk("stall_rd_ptr", rd_ptr, 7'd16);

        // Reset after word 3 of a burst.
        wr_ptr = 7'd24;
        req_ack("rst_mid");
        recv_burst(16, 32'hA500_0000, 0, 3, "rst_mid");
        chk("rst_mid_valid_before", strm_if.out_valid, 1'b1);
        nreset = 1'b0;
        #1;
        chk("rst_mid_valid", strm_if.out_valid, 1'b0);
        chk("rst_mid_data", strm_if.out_data, 32'd0);
        chk("rst_mid_last", strm_if.out_last, 1'b0);
        chk("rst_mid_req", strm_if.burst_req, 1'b0);
        chk("rst_mid_rd_ptr", rd_ptr, 7'd0);
        chk("rst_mid_addr", ram_addr_B, 6'd0);
        wr_ptr = 7'd0;
        tick();
        tick();
        nreset = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (strm_if.burst_req || strm_if.out_valid) seen++;
        end
        chk("post_rst_quiet", 64'(seen), 64'd0);

        // Full RAM: eight back-to-back bursts.
        wr_ptr = 7'd64;
        for (int b = 0; b < 8; b++) begin
            req_ack("full");
            recv_burst(8 * b, 32'hA500_0000, 0, 8, "full");
        end
        chk("full_rd_ptr", rd_ptr, 7'd64);
        tick();
        tick();
        chk("full_level0_no_req", strm_if.burst_req, 1'b0);

        // Second pass across the RAM with new contents; rd_ptr wraps 127 -> 0.
        fill_ram(32'h5A00_0000);
        wr_ptr = 7'd0;
        for (int b = 0; b < 8; b++) begin
            req_ack("wrap");
            recv_burst(8 * b, 32'h5A00_0000, (b == 7) ? 1 : 0, 8, "wrap");
        end
        chk("wrap_rd_ptr", rd_ptr, 7'd0);

        // Burst straight after the pointer wrap.
        wr_ptr = 7'd8;
        req_ack("after_wrap");
        recv_burst(0, 32'h5A00_0000, 0, 8, "after_wrap");
        chk("after_wrap_rd_ptr", rd_ptr, 7'd8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
